sccb_camera_init_seq: RTL

- Parametrised successor to the fixed OV7670 bring-up controller.
- Sequences camera power-up: PWDN release, timed hardware reset pulse, settle wait.
- Then walks an external register table, issuing writes to an SCCB master through a request/done handshake.
- Adds:
  - NACK retry with a bounded count.
  - In-table delay and end markers.
  - Restart on request.
  - Separate done and error status, so capture logic can gate on success.

---
 rtl/sccb_pkg.sv | 36 +++
 rtl/sccb_seq_timer.sv | 33 +++
 rtl/sccb_camera_init_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sccb_pkg                                                             |
// | Shared constants, state encoding and helpers for camera bring-up.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sccb_pkg;

  localparam logic [15:0] END_MARK        = 16'hFFFF;
  localparam logic [7:0]  DELAY_TAG       = 8'hFE;
  localparam logic [7:0]  OV7670_DEV_ADDR = 8'h42;

  typedef enum logic [3:0] {
    ST_PWDN   = 4'd0,
    ST_RST    = 4'd1,
    ST_SETTLE = 4'd2,
    ST_FETCH  = 4'd3,
    ST_DECODE = 4'd4,
    ST_SEND   = 4'd5,
    ST_WAIT   = 4'd6,
    ST_DELAY  = 4'd7,
    ST_DONE   = 4'd8,
    ST_ERROR  = 4'd9
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Timer reload value for an interval of n cycles (zero-length treated as one).
  function automatic int cycles_m1(input int n);
    return (n > 1) ? n - 1 : 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_seq_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sccb_seq_timer                                                       |
// | Loadable down-counter with a zero flag for the timed sequence steps. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sccb_seq_timer #(
  parameter int         W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sccb_camera_init_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sccb_camera_init_seq                                                 |
// | Camera power-up sequencing and SCCB register-table walker.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sccb_camera_init_seq
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR      = OV7670_DEV_ADDR,
  parameter int         TBL_DEPTH     = 256,
  parameter int         ADDR_W        = $clog2(TBL_DEPTH),
  parameter int         PWDN_CYCLES   = 1000000,
  parameter int         RST_CYCLES    = 100000,
  parameter int         SETTLE_CYCLES = 1000000,
  parameter int         DELAY_CYCLES  = 100000,
  parameter int         MAX_RETRIES   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_restart,
  output logic [ADDR_W-1:0] o_tbl_addr,
  input  logic [15:0]       i_tbl_data,
  output logic              o_sccb_req,
  output logic [7:0]        o_sccb_id,
  output logic [7:0]        o_sccb_reg,
  output logic [7:0]        o_sccb_val,
  input  logic              i_sccb_ready,
  input  logic              i_sccb_done,
  input  logic              i_sccb_nack,
  output logic              o_cam_pwdn,
  output logic              o_cam_reset_n,
  output logic              o_init_done,
  output logic              o_init_error,
  output logic [ADDR_W-1:0] o_err_index,
  output logic [ADDR_W:0]   o_regs_written
);

  localparam int CNT_MAX = max_int(max_int(PWDN_CYCLES, RST_CYCLES),
                                   max_int(SETTLE_CYCLES, 255 * DELAY_CYCLES));
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam int RTRY_W  = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]  PWDN_LOAD   = CNT_W'(cycles_m1(PWDN_CYCLES));
  localparam logic [CNT_W-1:0]  RST_LOAD    = CNT_W'(cycles_m1(RST_CYCLES));
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(cycles_m1(SETTLE_CYCLES));
  localparam logic [RTRY_W-1:0] RTRY_MAX    = RTRY_W'(MAX_RETRIES);
  localparam logic [ADDR_W:0]   IDX_END     = (ADDR_W + 1)'(TBL_DEPTH);

  seq_state_e        r_state;
  seq_state_e        w_next;

  logic [ADDR_W:0]   r_idx;
  logic [RTRY_W-1:0] r_retries;
  logic [7:0]        r_reg;
  logic [7:0]        r_val;
  logic [ADDR_W:0]   r_regs_written;
  logic [ADDR_W-1:0] r_err_index;
  logic              r_cam_pwdn;
  logic              r_cam_reset_n;

  logic              w_clear;
  logic              w_idx_clr;
  logic              w_idx_inc;
  logic              w_latch;
  logic              w_retry_inc;
  logic              w_wr_inc;
  logic              w_err_latch;
  logic              w_tmr_load;
  logic [CNT_W-1:0]  w_tmr_val;
  logic              w_tmr_zero;
  logic [CNT_W-1:0]  w_delay_len;

  // Reset presets the timer for the power-down interval so PWDN runs its full length.
  sccb_seq_timer #(
    .W       (CNT_W),
    .RST_VAL (PWDN_LOAD)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  assign w_delay_len = CNT_W'(i_tbl_data[7:0]) * CNT_W'(DELAY_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_PWDN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_clear     = 1'b0;
    w_idx_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    w_latch     = 1'b0;
    w_retry_inc = 1'b0;
    w_wr_inc    = 1'b0;
    w_err_latch = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;

    if (i_restart) begin
      w_next     = ST_PWDN;
      w_clear    = 1'b1;
      w_tmr_load = 1'b1;
      w_tmr_val  = PWDN_LOAD;
    end else begin
      case (r_state)
        ST_PWDN: begin
          if (w_tmr_zero) begin
            w_next     = ST_RST;
            w_tmr_load = 1'b1;
            w_tmr_val  = RST_LOAD;
          end
        end
        ST_RST: begin
          if (w_tmr_zero) begin
            w_next     = ST_SETTLE;
            w_tmr_load = 1'b1;
            w_tmr_val  = SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          if (w_tmr_zero) begin
            w_next    = ST_FETCH;
            w_idx_clr = 1'b1;
          end
        end
        ST_FETCH: begin
          w_next = ST_DECODE;
        end
        ST_DECODE: begin
          if ((r_idx == IDX_END) || (i_tbl_data == END_MARK)) begin
            w_next = ST_DONE;
          end else if (i_tbl_data[15:8] == DELAY_TAG) begin
            // A zero-length delay marker is simply stepped over.
            if (w_delay_len != '0) begin
              w_next     = ST_DELAY;
              w_tmr_load = 1'b1;
              w_tmr_val  = w_delay_len - 1'b1;
            end else begin
              w_next    = ST_FETCH;
              w_idx_inc = 1'b1;
            end
          end else begin
            w_next  = ST_SEND;
            w_latch = 1'b1;
          end
        end
        ST_SEND: begin
          if (i_sccb_ready) begin
            w_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_sccb_done) begin
            if (!i_sccb_nack) begin
              w_next    = ST_FETCH;
              w_wr_inc  = 1'b1;
              w_idx_inc = 1'b1;
            end else if (r_retries < RTRY_MAX) begin
              w_next      = ST_SEND;
              w_retry_inc = 1'b1;
            end else begin
              w_next      = ST_ERROR;
              w_err_latch = 1'b1;
            end
          end
        end
        ST_DELAY: begin
          if (w_tmr_zero) begin
            w_next    = ST_FETCH;
            w_idx_inc = 1'b1;
          end
        end
        ST_DONE, ST_ERROR: begin
          w_next = r_state;
        end
        default: begin
          w_next     = ST_PWDN;
          w_clear    = 1'b1;
          w_tmr_load = 1'b1;
          w_tmr_val  = PWDN_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_idx          <= '0;
      r_retries      <= '0;
      r_reg          <= '0;
      r_val          <= '0;
      r_regs_written <= '0;
      r_err_index    <= '0;
    end else begin
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_latch) begin
        r_reg     <= i_tbl_data[15:8];
        r_val     <= i_tbl_data[7:0];
        r_retries <= '0;
      end else if (w_retry_inc) begin
        r_retries <= r_retries + 1'b1;
      end
      if (w_wr_inc) begin
        r_regs_written <= r_regs_written + 1'b1;
      end
      if (w_err_latch) begin
        r_err_index <= r_idx[ADDR_W-1:0];
      end
    end
  end

  // Camera pins come straight from flops so they never glitch off-chip.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cam_pwdn    <= 1'b1;
      r_cam_reset_n <= 1'b0;
    end else begin
      r_cam_pwdn    <= (w_next == ST_PWDN);
      r_cam_reset_n <= !((w_next == ST_PWDN) || (w_next == ST_RST));
    end
  end

  assign o_tbl_addr     = r_idx[ADDR_W-1:0];
  assign o_sccb_req     = (r_state == ST_SEND);
  assign o_sccb_id      = DEV_ADDR;
  assign o_sccb_reg     = r_reg;
  assign o_sccb_val     = r_val;
  assign o_cam_pwdn     = r_cam_pwdn;
  assign o_cam_reset_n  = r_cam_reset_n;
  assign o_init_done    = (r_state == ST_DONE);
  assign o_init_error   = (r_state == ST_ERROR);
  assign o_err_index    = r_err_index;
  assign o_regs_written = r_regs_written;

endmodule
`default_nettype wire
